// File: rtl/digit_alu.sv
// rtl/digit_alu.sv - single-digit mod-10 add/sub/mul ALU with a 4-iteration restoring divider.
// Optional macro HIGH_DIGIT_EN adds the hi output (tens digit / borrow / remainder).
module digit_alu (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [1:0] op,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       ready,
  output logic       out_valid,
  output logic [3:0] result,
`ifdef HIGH_DIGIT_EN
  output logic [3:0] hi,
`endif
  output logic       err
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;
  localparam logic [3:0] ERR_CODE = 4'd11;

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_FIN} state_t;

  state_t     r_state;
  logic [1:0] r_cnt;
  logic [3:0] r_quo;
  logic [3:0] r_rem;
  logic [3:0] r_dvs;

  logic       w_bad;
  logic       w_err;
  logic       w_start_div;
  logic [4:0] w_sum;
  logic       w_add_hi;
  logic [3:0] w_add_lo;
  logic       w_borrow;
  logic [3:0] w_sub_lo;
  logic [6:0] w_prod;
  logic [3:0] w_mul_hi;
  logic [3:0] w_mul_lo;
  logic [3:0] w_res;
`ifdef HIGH_DIGIT_EN
  logic [3:0] w_hi;
`endif
  logic [4:0] w_shift;
  logic       w_fits;
  logic [3:0] w_rem_nxt;
  logic [3:0] w_quo_nxt;

  assign w_bad       = (a > 4'd9) || (b > 4'd9);
  assign w_err       = w_bad || ((op == OP_DIV) && (b == 4'd0));
  assign w_start_div = (op == OP_DIV) && !w_err;

  assign w_sum    = {1'b0, a} + {1'b0, b};
  assign w_add_hi = (w_sum >= 5'd10);
  assign w_add_lo = w_add_hi ? 4'(w_sum - 5'd10) : w_sum[3:0];

  assign w_borrow = (a < b);
  assign w_sub_lo = w_borrow ? 4'({1'b0, a} + 5'd10 - {1'b0, b}) : (a - b);

  assign w_prod = 7'(a) * 7'(b);

  // Tens digit by threshold comparison; the ones digit is what is left.
  always_comb begin
    w_mul_hi = 4'd0;
    for (int k = 1; k <= 8; k++) begin
      if (w_prod >= 7'(10 * k)) w_mul_hi = 4'(k);
    end
    w_mul_lo = 4'(w_prod - 7'(10 * w_mul_hi));
  end

  always_comb begin
    w_res = ERR_CODE;
`ifdef HIGH_DIGIT_EN
    w_hi  = ERR_CODE;
`endif
    if (!w_err) begin
      case (op)
        OP_ADD: begin
          w_res = w_add_lo;
`ifdef HIGH_DIGIT_EN
          w_hi  = {3'b000, w_add_hi};
`endif
        end
        OP_SUB: begin
          w_res = w_sub_lo;
`ifdef HIGH_DIGIT_EN
          w_hi  = {3'b000, w_borrow};
`endif
        end
        OP_MUL: begin
          w_res = w_mul_lo;
`ifdef HIGH_DIGIT_EN
          w_hi  = w_mul_hi;
`endif
        end
        default: ;
      endcase
    end
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  assign w_shift   = {r_rem, r_quo[3]};
  assign w_fits    = (w_shift >= {1'b0, r_dvs});
  assign w_rem_nxt = w_fits ? 4'(w_shift - {1'b0, r_dvs}) : w_shift[3:0];
  assign w_quo_nxt = {r_quo[2:0], w_fits};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= 2'd0;
      r_quo     <= 4'd0;
      r_rem     <= 4'd0;
      r_dvs     <= 4'd0;
      ready     <= 1'b1;
      out_valid <= 1'b0;
      result    <= ERR_CODE;
      err       <= 1'b0;
`ifdef HIGH_DIGIT_EN
      hi        <= ERR_CODE;
`endif
    end else begin
      out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            if (w_start_div) begin
              r_state <= S_DIV;
              ready   <= 1'b0;
              r_cnt   <= 2'd3;
              r_quo   <= a;
              r_rem   <= 4'd0;
              r_dvs   <= b;
            end else begin
              out_valid <= 1'b1;
              result    <= w_res;
              err       <= w_err;
`ifdef HIGH_DIGIT_EN
              hi        <= w_hi;
`endif
            end
          end
        end
        S_DIV: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt - 2'd1;
          if (r_cnt == 2'd0) r_state <= S_FIN;
        end
        S_FIN: begin
          out_valid <= 1'b1;
          result    <= r_quo;
          err       <= 1'b0;
`ifdef HIGH_DIGIT_EN
          hi        <= r_rem;
`endif
          ready     <= 1'b1;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_digit_alu.sv
// tb/tb_digit_alu.sv - directed and random checks of digit_alu against an arithmetic reference model.
module tb_digit_alu;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [1:0] op;
  logic [3:0] a;
  logic [3:0] b;
  logic       ready;
  logic       out_valid;
  logic [3:0] result;
  logic       err;
`ifdef HIGH_DIGIT_EN
  logic [3:0] hi;
`endif

  int n_checks = 0;
  int n_errs   = 0;

  digit_alu dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .op       (op),
    .a        (a),
    .b        (b),
    .ready    (ready),
    .out_valid(out_valid),
    .result   (result),
`ifdef HIGH_DIGIT_EN
    .hi       (hi),
`endif
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: plain decimal arithmetic on integers.
  task automatic model(input int m_op, input int m_a, input int m_b,
                       output int r, output int h, output bit e, output bit slow);
    r = 11; h = 11; e = 1'b1; slow = 1'b0;
    if (m_a <= 9 && m_b <= 9) begin
      case (m_op)
        0: begin r = (m_a + m_b) % 10; h = (m_a + m_b) / 10; e = 1'b0; end
        1: begin r = (m_a - m_b + 10) % 10; h = (m_a < m_b) ? 1 : 0; e = 1'b0; end
        2: begin r = (m_a * m_b) % 10; h = (m_a * m_b) / 10; e = 1'b0; end
        default: if (m_b != 0) begin r = m_a / m_b; h = m_a % m_b; e = 1'b0; slow = 1'b1; end
      endcase
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string tag, input int t_op, input int t_a, input int t_b);
    int  er, eh;
    bit  ee, slow;
    model(t_op, t_a, t_b, er, eh, ee, slow);
    op = 2'(t_op); a = 4'(t_a); b = 4'(t_b); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    if (slow) begin
      chk({tag, "_ready_drop"}, ready, 0);
      for (int i = 1; i <= 4; i++) begin
        tick();
        chk({tag, "_busy_ready"}, ready, 0);
        chk({tag, "_busy_ov"}, out_valid, 0);
      end
      tick();
    end
    chk({tag, "_ov"}, out_valid, 1);
    chk({tag, "_ready"}, ready, 1);
    chk({tag, "_result"}, result, er);
    chk({tag, "_err"}, err, ee);
`ifdef HIGH_DIGIT_EN
    chk({tag, "_hi"}, hi, eh);
`endif
  endtask

  initial begin
    bit seen;
    reset = 1'b0; in_valid = 1'b0; op = 2'd0; a = 4'd0; b = 4'd0;
    #12;
    chk("rst_ready", ready, 1);
    chk("rst_ov", out_valid, 0);
    chk("rst_result", result, 11);
    chk("rst_err", err, 0);
`ifdef HIGH_DIGIT_EN
    chk("rst_hi", hi, 11);
`endif
    reset = 1'b1;
    tick();

    op = 2'd0; a = 4'd7; b = 4'd5; in_valid = 1'b1;
    tick();
    chk("b2b_add_ov", out_valid, 1);
    chk("b2b_add_res", result, 2);
    op = 2'd1; a = 4'd3; b = 4'd5;
    tick();
    chk("b2b_sub_ov", out_valid, 1);
    chk("b2b_sub_res", result, 8);
    op = 2'd2; a = 4'd9; b = 4'd9;
    tick();
    chk("b2b_mul_ov", out_valid, 1);
    chk("b2b_mul_res", result, 1);
    chk("b2b_ready", ready, 1);
    in_valid = 1'b0;
    tick();
    chk("b2b_idle_ov", out_valid, 0);
    chk("b2b_hold_res", result, 1);

    run("div_9_2", 3, 9, 2);
    run("div_2_9", 3, 2, 9);
    run("div_by0", 3, 6, 0);
    run("bad_add", 0, 12, 3);
    run("mul_7_8", 2, 7, 8);
    run("div_9_4", 3, 9, 4);
    run("sub_3_5", 1, 3, 5);
    run("add_9_9", 0, 9, 9);
    run("sub_0_0", 1, 0, 0);
    run("bad_div", 3, 4, 10);

    op = 2'd3; a = 4'd8; b = 4'd3; in_valid = 1'b1;
    tick();
    op = 2'd0; a = 4'd1; b = 4'd1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("ign_busy_ov", out_valid, 0);
    end
    tick();
    chk("ign_div_ov", out_valid, 1);
    chk("ign_div_res", result, 2);
    in_valid = 1'b0;
    tick();
    chk("ign_no_queue_ov", out_valid, 0);
    chk("ign_hold_res", result, 2);

    op = 2'd3; a = 4'd9; b = 4'd2; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    chk("mid_rst_ready", ready, 1);
    chk("mid_rst_result", result, 11);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_ov", out_valid, 0);
    #2;
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid === 1'b1) seen = 1'b1;
    end
    chk("mid_rst_no_pulse", seen, 0);
    chk("mid_rst_ready_after", ready, 1);

    for (int i = 0; i < 150; i++) begin
      run("rand", int'($urandom_range(0, 3)), int'($urandom_range(0, 11)), int'($urandom_range(0, 11)));
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
